expr_tokenizer: RTL

Upstream front-end of the math-solver datapath. Consumes an ASCII expression one character at a time over a valid/ready handshake, e.g. "5*(4-2+1)-6=". Parses multi-digit decimal operands and emits a fixed-size token buffer in the solver's infix layout: plane 0 holds the value or operator ASCII code, plane 1 holds the operator flag. Asserts done once a terminator is seen, and error on any malformed input.

---
 rtl/math_pkg.sv | 29 ++
 rtl/char_classifier.sv | 24 ++
 rtl/expr_tokenizer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared definitions for the math-solver datapath:
// ASCII codes, tokenizer states and the token layout.
package math_pkg;

  localparam logic [7:0] CH_PLUS  = 8'd43;
  localparam logic [7:0] CH_MINUS = 8'd45;
  localparam logic [7:0] CH_MUL   = 8'd42;
  localparam logic [7:0] CH_DIV   = 8'd47;
  localparam logic [7:0] CH_LPAR  = 8'd40;
  localparam logic [7:0] CH_RPAR  = 8'd41;
  localparam logic [7:0] CH_EQ    = 8'd61;
  localparam logic [7:0] CH_LF    = 8'd10;
  localparam logic [7:0] CH_SP    = 8'd32;

  localparam int TOK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } tok_state_e;

  typedef struct packed {
    logic [TOK_W-1:0] value;
    logic             is_op;
  } token_t;

endpackage

// File: rtl/char_classifier.sv
// Combinational ASCII classifier for the expression tokenizer.
// Exactly one class flag is high for any input byte.
module char_classifier
  import math_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_op,
  output logic       is_space,
  output logic       is_term,
  output logic       is_invalid
);

  assign is_digit = (char_in >= 8'd48) && (char_in <= 8'd57);
  // '0'..'9' are 0x30..0x39, so the low nibble is the value
  assign digit    = char_in[3:0];
  assign is_op    = char_in inside {CH_PLUS, CH_MINUS, CH_MUL,
                                    CH_DIV, CH_LPAR, CH_RPAR};
  assign is_space = (char_in == CH_SP);
  assign is_term  = (char_in == CH_EQ) || (char_in == CH_LF);
  assign is_invalid = !(is_digit || is_op || is_space || is_term);

endmodule

// File: rtl/expr_tokenizer.sv
// Character-stream tokenizer: builds the solver's infix token buffer
// from an ASCII expression, with done/error status.
module expr_tokenizer
  import math_pkg::*;
#(
  parameter  int LEN   = 11,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(LEN+1)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              clear,
  input  logic [7:0]                        char_in,
  input  logic                              char_valid,
  output logic                              char_ready,
  output logic [1:0][LEN-1:0][WIDTH-1:0]    infix,
  output logic [CW-1:0]                     token_count,
  output logic                              done,
  output logic                              error
);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  tok_state_e       state;
  logic [WIDTH-1:0] acc;

  logic       c_digit, c_op, c_space, c_term, c_invalid;
  logic [3:0] dig;

  char_classifier u_cls (
    .char_in    (char_in),
    .is_digit   (c_digit),
    .digit      (dig),
    .is_op      (c_op),
    .is_space   (c_space),
    .is_term    (c_term),
    .is_invalid (c_invalid)
  );

  logic [WIDTH+3:0] acc_nxt;
  logic             acc_ovf;
  logic [CW-1:0]    cnt_p1;
  logic [CW-1:0]    cnt_p2;
  logic             room1;
  logic             room2;
  logic             accept;

  // Extra 4 bits hold acc*10+d without wrap so overflow is visible
  assign acc_nxt = ({4'b0, acc} * (WIDTH+4)'(10)) + (WIDTH+4)'(dig);
  assign acc_ovf = |acc_nxt[WIDTH+3:WIDTH];

  assign cnt_p1 = token_count + CW'(1);
  assign cnt_p2 = token_count + CW'(2);
  assign room1  = token_count < LEN_C;
  assign room2  = cnt_p1 < LEN_C;

  assign char_ready = (state == IDLE) || (state == NUM);
  assign accept     = char_valid && char_ready;
  assign done       = (state == DONE);
  assign error      = (state == ERR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      acc         <= '0;
      infix       <= '0;
      token_count <= '0;
    end else if (clear) begin
      state       <= IDLE;
      acc         <= '0;
      infix       <= '0;
      token_count <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            c_digit: begin
              acc   <= WIDTH'(dig);
              state <= NUM;
            end
            c_op: begin
              if (room1) begin
                infix[0][token_count] <= WIDTH'(char_in);
                infix[1][token_count] <= WIDTH'(1);
                token_count           <= cnt_p1;
              end else begin
                state <= ERR;
              end
            end
            c_space: begin
            end
            c_term: state <= (token_count != '0) ? DONE : ERR;
            c_invalid: state <= ERR;
            default: state <= ERR;
          endcase
        end
        NUM: begin
          unique case (1'b1)
            c_digit: begin
              if (acc_ovf) state <= ERR;
              else         acc   <= acc_nxt[WIDTH-1:0];
            end
            c_space: begin
              if (room1) begin
                infix[0][token_count] <= acc;
                infix[1][token_count] <= '0;
                token_count           <= cnt_p1;
                state                 <= IDLE;
              end else begin
                state <= ERR;
              end
            end
            // Number and operator land together; both or neither
            c_op: begin
              if (room2) begin
                infix[0][token_count] <= acc;
                infix[1][token_count] <= '0;
                infix[0][cnt_p1]      <= WIDTH'(char_in);
                infix[1][cnt_p1]      <= WIDTH'(1);
                token_count           <= cnt_p2;
                state                 <= IDLE;
              end else begin
                state <= ERR;
              end
            end
            c_term: begin
              if (room1) begin
                infix[0][token_count] <= acc;
                infix[1][token_count] <= '0;
                token_count           <= cnt_p1;
                state                 <= DONE;
              end else begin
                state <= ERR;
              end
            end
            c_invalid: state <= ERR;
            default: state <= ERR;
          endcase
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule
